// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle controller: ALU classes, opcodes,
// mux selects, FSM states and latched instruction classes.
package multicycle_control_pkg;

    // ALU class handed to the alucontroller
    localparam logic [2:0] ALUOP_R_TYPE       = 3'd0;
    localparam logic [2:0] ALUOP_IMMEDIATE    = 3'd1;
    localparam logic [2:0] ALUOP_LUI          = 3'd2;
    localparam logic [2:0] ALUOP_LOADS_STORES = 3'd3;
    localparam logic [2:0] ALUOP_BRANCHES     = 3'd4;

    // Major opcodes (instr[6:0])
    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // ALU operand selects
    localparam logic       SRCA_RS1  = 1'b0;
    localparam logic       SRCA_PC   = 1'b1;
    localparam logic [1:0] SRCB_RS2  = 2'd0;
    localparam logic [1:0] SRCB_IMM  = 2'd1;
    localparam logic [1:0] SRCB_FOUR = 2'd2;

    // Register-file writeback source
    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEMORY,
        S_WRITEBACK,
        S_TRAP
    } state_e;

    typedef enum logic [3:0] {
        CLS_NONE,
        CLS_R,
        CLS_I,
        CLS_LUI,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JAL,
        CLS_JALR,
        CLS_ILLEGAL
    } iclass_e;

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle. The controller itself keeps flat ports so
// it drops into existing netlists; surrounding logic can carry the signals
// through this interface.
interface multicycle_control_if;
    import multicycle_control_pkg::*;

    logic [31:0] instr;
    logic        mem_ready;
    logic [2:0]  alu_op;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic        mem_req;
    logic        mem_we;
    logic        mem_addr_sel;
    logic        ir_write;
    logic        pc_write;
    logic        pc_write_cond;
    logic        pc_src;
    logic        reg_write;
    logic [1:0]  wb_sel;
    logic        trap;

    // Controller side
    modport master (
        input  instr, mem_ready,
        output alu_op, alu_src_a, alu_src_b, mem_req, mem_we, mem_addr_sel,
               ir_write, pc_write, pc_write_cond, pc_src, reg_write, wb_sel,
               trap
    );

    // Datapath / memory side
    modport slave (
        output instr, mem_ready,
        input  alu_op, alu_src_a, alu_src_b, mem_req, mem_we, mem_addr_sel,
               ir_write, pc_write, pc_write_cond, pc_src, reg_write, wb_sel,
               trap
    );

endinterface

// File: rtl/multicycle_control_opcode_decoder.sv
// Combinational major-opcode to instruction-class decoder. Funct fields are
// validated downstream, so only the 7-bit opcode is inspected here.
module opcode_decoder
    import multicycle_control_pkg::*;
(
    input  logic [6:0] opcode_i,
    output iclass_e    class_o
);

    // Map each recognised opcode to its class; anything else is illegal
    always_comb begin
        class_o = CLS_ILLEGAL;
        case (opcode_i)
            OPC_R:      class_o = CLS_R;
            OPC_I:      class_o = CLS_I;
            OPC_LUI:    class_o = CLS_LUI;
            OPC_LOAD:   class_o = CLS_LOAD;
            OPC_STORE:  class_o = CLS_STORE;
            OPC_BRANCH: class_o = CLS_BRANCH;
            OPC_JAL:    class_o = CLS_JAL;
            OPC_JALR:   class_o = CLS_JALR;
            default:    class_o = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RISC-V style main controller: FETCH / DECODE / EXECUTE /
// MEMORY / WRITEBACK sequencing with an absorbing TRAP state for
// unrecognised opcodes.
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    output logic [2:0]  alu_op,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        pc_src,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic        trap
);

    state_e  state_q;
    iclass_e class_q;
    iclass_e dec_class;

    // Only the opcode steers sequencing; upper bits belong to the datapath.
    logic unused_instr_bits;
    assign unused_instr_bits = ^instr[31:7];

    opcode_decoder u_opcode_decoder (
        .opcode_i (instr[6:0]),
        .class_o  (dec_class)
    );

    // State sequencing; the class is captured once when DECODE is left
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            class_q <= CLS_NONE;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (mem_ready) state_q <= S_DECODE;
                end
                S_DECODE: begin
                    class_q <= dec_class;
                    state_q <= (dec_class == CLS_ILLEGAL) ? S_TRAP : S_EXECUTE;
                end
                S_EXECUTE: begin
                    case (class_q)
                        CLS_LOAD, CLS_STORE: state_q <= S_MEMORY;
                        CLS_BRANCH:          state_q <= S_FETCH;
                        default:             state_q <= S_WRITEBACK;
                    endcase
                end
                S_MEMORY: begin
                    if (mem_ready) begin
                        state_q <= (class_q == CLS_STORE) ? S_FETCH : S_WRITEBACK;
                    end
                end
                S_WRITEBACK: state_q <= S_FETCH;
                S_TRAP:      state_q <= S_TRAP;
                default:     state_q <= S_FETCH;
            endcase
        end
    end

    // Control outputs from the current state; FETCH strobes follow mem_ready.
    // While rst is high the FETCH operand defaults show but no request or
    // register load is issued, whatever state the FSM was caught in.
    always_comb begin
        alu_op        = ALUOP_R_TYPE;
        alu_src_a     = SRCA_RS1;
        alu_src_b     = SRCB_RS2;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr_sel  = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = 1'b0;
        reg_write     = 1'b0;
        wb_sel        = WB_ALU;
        trap          = 1'b0;
        if (rst) begin
            alu_op    = ALUOP_LOADS_STORES;
            alu_src_a = SRCA_PC;
            alu_src_b = SRCB_FOUR;
        end else begin
            case (state_q)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    alu_op    = ALUOP_LOADS_STORES;
                    alu_src_a = SRCA_PC;
                    alu_src_b = SRCB_FOUR;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_EXECUTE: begin
                    case (class_q)
                        CLS_R: begin
                            alu_op = ALUOP_R_TYPE;
                        end
                        CLS_I: begin
                            alu_op    = ALUOP_IMMEDIATE;
                            alu_src_b = SRCB_IMM;
                        end
                        CLS_LUI: begin
                            alu_op    = ALUOP_LUI;
                            alu_src_b = SRCB_IMM;
                        end
                        CLS_LOAD, CLS_STORE: begin
                            alu_op    = ALUOP_LOADS_STORES;
                            alu_src_b = SRCB_IMM;
                        end
                        CLS_JALR: begin
                            alu_op    = ALUOP_LOADS_STORES;
                            alu_src_b = SRCB_IMM;
                            pc_write  = 1'b1;
                        end
                        CLS_BRANCH: begin
                            alu_op        = ALUOP_BRANCHES;
                            pc_write_cond = 1'b1;
                            pc_src        = 1'b1;
                        end
                        CLS_JAL: begin
                            pc_write = 1'b1;
                            pc_src   = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_MEMORY: begin
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                    mem_we       = (class_q == CLS_STORE);
                end
                S_WRITEBACK: begin
                    reg_write = 1'b1;
                    case (class_q)
                        CLS_LOAD:          wb_sel = WB_MEM;
                        CLS_JAL, CLS_JALR: wb_sel = WB_PC4;
                        default:           wb_sel = WB_ALU;
                    endcase
                end
                S_TRAP: begin
                    trap = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed scenarios plus
// randomized instruction streams compared cycle-by-cycle against expected
// output sequences built per instruction from the controller's rules.
module tb_multicycle_control;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       src_a;
        logic [1:0] src_b;
        logic       mem_req;
        logic       mem_we;
        logic       mem_addr_sel;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       pc_src;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic       trap;
    } ov_t;

    localparam int K_R    = 0;
    localparam int K_I    = 1;
    localparam int K_LUI  = 2;
    localparam int K_LD   = 3;
    localparam int K_ST   = 4;
    localparam int K_BR   = 5;
    localparam int K_JAL  = 6;
    localparam int K_JALR = 7;
    localparam int K_ILL  = 8;

    logic clk = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;

    multicycle_control_if bus ();

    multicycle_control dut (
        .clk           (clk),
        .rst           (rst),
        .instr         (bus.instr),
        .mem_ready     (bus.mem_ready),
        .alu_op        (bus.alu_op),
        .alu_src_a     (bus.alu_src_a),
        .alu_src_b     (bus.alu_src_b),
        .mem_req       (bus.mem_req),
        .mem_we        (bus.mem_we),
        .mem_addr_sel  (bus.mem_addr_sel),
        .ir_write      (bus.ir_write),
        .pc_write      (bus.pc_write),
        .pc_write_cond (bus.pc_write_cond),
        .pc_src        (bus.pc_src),
        .reg_write     (bus.reg_write),
        .wb_sel        (bus.wb_sel),
        .trap          (bus.trap)
    );

    always #5 clk = ~clk;

    function automatic int kind_of(input logic [6:0] opc);
        case (opc)
            7'b0110011: return K_R;
            7'b0010011: return K_I;
            7'b0110111: return K_LUI;
            7'b0000011: return K_LD;
            7'b0100011: return K_ST;
            7'b1100011: return K_BR;
            7'b1101111: return K_JAL;
            7'b1100111: return K_JALR;
            default:    return K_ILL;
        endcase
    endfunction

    function automatic logic [31:0] rand_instr(input int kind);
        logic [6:0]  opc [8];
        logic [31:0] w;
        opc = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0000011,
                7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111};
        w = $urandom;
        if (kind == K_ILL) begin
            while (kind_of(w[6:0]) != K_ILL) w = $urandom;
            return w;
        end
        return {w[31:7], opc[kind]};
    endfunction

    function automatic ov_t sample();
        ov_t o;
        o.alu_op        = bus.alu_op;
        o.src_a         = bus.alu_src_a;
        o.src_b         = bus.alu_src_b;
        o.mem_req       = bus.mem_req;
        o.mem_we        = bus.mem_we;
        o.mem_addr_sel  = bus.mem_addr_sel;
        o.ir_write      = bus.ir_write;
        o.pc_write      = bus.pc_write;
        o.pc_write_cond = bus.pc_write_cond;
        o.pc_src        = bus.pc_src;
        o.reg_write     = bus.reg_write;
        o.wb_sel        = bus.wb_sel;
        o.trap          = bus.trap;
        return o;
    endfunction

    function automatic ov_t reset_ov();
        ov_t o = '0;
        o.alu_op = 3'd3;
        o.src_a  = 1'b1;
        o.src_b  = 2'd2;
        return o;
    endfunction

    function automatic ov_t fetch_ov(input logic rdy);
        ov_t o = reset_ov();
        o.mem_req  = 1'b1;
        o.ir_write = rdy;
        o.pc_write = rdy;
        return o;
    endfunction

    function automatic ov_t exec_ov(input int kind);
        ov_t o = '0;
        case (kind)
            K_R:   o.alu_op = 3'd0;
            K_I:   begin o.alu_op = 3'd1; o.src_b = 2'd1; end
            K_LUI: begin o.alu_op = 3'd2; o.src_b = 2'd1; end
            K_LD, K_ST: begin o.alu_op = 3'd3; o.src_b = 2'd1; end
            K_JALR: begin o.alu_op = 3'd3; o.src_b = 2'd1; o.pc_write = 1'b1; end
            K_BR:  begin o.alu_op = 3'd4; o.pc_write_cond = 1'b1; o.pc_src = 1'b1; end
            K_JAL: begin o.pc_write = 1'b1; o.pc_src = 1'b1; end
            default: ;
        endcase
        return o;
    endfunction

    function automatic ov_t mem_ov(input logic store);
        ov_t o = '0;
        o.mem_req      = 1'b1;
        o.mem_addr_sel = 1'b1;
        o.mem_we       = store;
        return o;
    endfunction

    function automatic ov_t wb_ov(input int kind);
        ov_t o = '0;
        o.reg_write = 1'b1;
        if (kind == K_LD) o.wb_sel = 2'd1;
        else if (kind == K_JAL || kind == K_JALR) o.wb_sel = 2'd2;
        return o;
    endfunction

    function automatic ov_t trap_ov();
        ov_t o = '0;
        o.trap = 1'b1;
        return o;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Drive one cycle of inputs after the falling edge, then check outputs
    task automatic step(input logic r, input logic rdy, input logic [31:0] ins,
                        input ov_t exp, input string tag);
        ov_t obs;
        @(negedge clk);
        rst           = r;
        bus.mem_ready = rdy;
        bus.instr     = ins;
        #1;
        obs = sample();
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full instruction starting in FETCH: f stalled fetch cycles, m
    // stalled memory cycles, ntrap cycles observed in TRAP for illegal ones
    task automatic run_instr(input logic [31:0] ins, input int unsigned f,
                             input int unsigned m, input int unsigned ntrap,
                             input string tag);
        int kind = kind_of(ins[6:0]);
        for (int unsigned i = 0; i < f; i++)
            step(1'b0, 1'b0, $urandom, fetch_ov(1'b0), {tag, "/fetch_wait"});
        step(1'b0, 1'b1, $urandom, fetch_ov(1'b1), {tag, "/fetch_done"});
        step(1'b0, rbit(), ins, '0, {tag, "/decode"});
        if (kind == K_ILL) begin
            for (int unsigned i = 0; i < ntrap; i++)
                step(1'b0, 1'(i & 1), $urandom, trap_ov(), {tag, "/trap"});
            return;
        end
        step(1'b0, rbit(), $urandom, exec_ov(kind), {tag, "/execute"});
        if (kind == K_LD || kind == K_ST) begin
            for (int unsigned i = 0; i < m; i++)
                step(1'b0, 1'b0, $urandom, mem_ov(kind == K_ST), {tag, "/mem_wait"});
            step(1'b0, 1'b1, $urandom, mem_ov(kind == K_ST), {tag, "/mem_done"});
        end
        if (kind != K_ST && kind != K_BR)
            step(1'b0, rbit(), $urandom, wb_ov(kind), {tag, "/writeback"});
    endtask

    initial begin
        rst           = 1'b1;
        bus.mem_ready = 1'b0;
        bus.instr     = '0;

        step(1'b1, 1'b0, 32'h0, reset_ov(), "reset_idle");
        step(1'b1, 1'b1, $urandom, reset_ov(), "reset_ready_high");

        run_instr(32'h002081B3, 2, 0, 0, "add");
        run_instr(32'h0000A183, 0, 3, 0, "lw");
        run_instr(32'h0020A023, 1, 1, 0, "sw");
        run_instr(32'h00208463, 0, 0, 0, "beq");
        run_instr(rand_instr(K_JAL), 0, 0, 0, "jal");
        run_instr(rand_instr(K_JALR), 1, 0, 0, "jalr");
        run_instr(rand_instr(K_LUI), 0, 0, 0, "lui");
        run_instr(rand_instr(K_I), 0, 0, 0, "addi");

        // Reset while a store waits in MEMORY
        step(1'b0, 1'b1, $urandom, fetch_ov(1'b1), "rst_mem/fetch_done");
        step(1'b0, 1'b0, 32'h0020A023, '0, "rst_mem/decode");
        step(1'b0, 1'b0, $urandom, exec_ov(K_ST), "rst_mem/execute");
        step(1'b0, 1'b0, $urandom, mem_ov(1'b1), "rst_mem/mem_wait0");
        step(1'b0, 1'b0, $urandom, mem_ov(1'b1), "rst_mem/mem_wait1");
        step(1'b1, 1'b1, $urandom, reset_ov(), "rst_mem/in_reset");
        step(1'b0, 1'b0, $urandom, fetch_ov(1'b0), "rst_mem/after_reset");
        run_instr(rand_instr(K_R), 0, 0, 0, "post_rst_r");

        // Reset caught mid-fetch with mem_ready high
        step(1'b1, 1'b1, $urandom, reset_ov(), "rst_fetch/in_reset");
        run_instr(rand_instr(K_LD), 1, 0, 0, "post_rst_lw");

        // Randomized instruction stream
        for (int unsigned n = 0; n < 60; n++) begin
            int kind = int'($urandom_range(0, 8));
            run_instr(rand_instr(kind), $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(1, 4), "rand");
            if (kind == K_ILL) begin
                step(1'b1, rbit(), $urandom, reset_ov(), "rand/trap_reset");
            end
        end

        // Illegal all-zero word: absorbing trap, then cleared by reset
        run_instr(32'h00000000, 0, 0, 20, "illegal");
        step(1'b1, 1'b1, $urandom, reset_ov(), "illegal/reset");
        step(1'b0, 1'b0, $urandom, fetch_ov(1'b0), "illegal/after_reset");
        run_instr(rand_instr(K_BR), 0, 0, 0, "post_trap_beq");
        step(1'b0, 1'b0, $urandom, fetch_ov(1'b0), "final_fetch");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have ports, clock and reset first:
- clk  in  1  rising-edge clock
- rst  in  1  reset
- instr  in  32  instruction register contents, valid from DECODE onward
- mem_ready  in  1  memory handshake completion
- alu_op  out  3  ALU class to alucontroller: 0 R_type, 1 Immediate, 2 LUI, 3 loads_stores, 4 branches
- alu_src_a  out  1  0 = rs1, 1 = PC
- alu_src_b  out  2  0 = rs2, 1 = immediate, 2 = constant 4
- mem_req  out  1  memory request
- mem_we  out  1  store
- mem_addr_sel  out  1  0 = PC, 1 = ALU result
- ir_write  out  1  load instruction register
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if branch condition true
- pc_src  out  1  0 = ALU result, 1 = branch/jump target
- reg_write  out  1  register-file write enable
- wb_sel  out  2  0 = ALU, 1 = memory data, 2 = PC+4
- trap  out  1  sticky illegal-instruction flag
REQ-002 SHALL use a single clock, clk; reset is synchronous and active-high, named rst.

Function
REQ-003 SHALL implement states FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK and TRAP.
REQ-004 In FETCH, SHALL drive mem_req=1, mem_addr_sel=0, alu_src_a=1, alu_src_b=2 and alu_op=3.
REQ-005 In FETCH, ir_write and pc_write SHALL equal mem_ready (Mealy); the FSM stays in FETCH until mem_ready=1, then goes to DECODE.
REQ-006 DECODE SHALL last exactly 1 cycle, with all enables 0.
REQ-007 On leaving DECODE, the FSM SHALL decode instr[6:0]:
- 0110011 R, 0010011 I, 0110111 LUI, 0000011 LOAD, 0100011 STORE, 1100011 BRANCH, 1101111 JAL, 1100111 JALR go to EXECUTE.
- Any other opcode goes to TRAP.
REQ-008 EXECUTE SHALL last 1 cycle and drive alu_op and sources per class:
- R: op 0, a=rs1, b=rs2.
- I: op 1, b=imm.
- LUI: op 2, b=imm.
- LOAD/STORE/JALR: op 3, b=imm.
- BRANCH: op 4, b=rs2, pc_write_cond=1, pc_src=1.
- JAL: pc_write=1, pc_src=1.
REQ-009 From EXECUTE, next state SHALL be:
- LOAD/STORE: MEMORY.
- BRANCH: FETCH.
- JALR: pc_write=1, pc_src=0 this cycle, then WRITEBACK.
- All others: WRITEBACK.
REQ-010 MEMORY SHALL hold mem_req=1, mem_addr_sel=1, and mem_we=1 for STORE, until mem_ready=1.
REQ-011 On MEMORY completion, STORE SHALL go to FETCH and LOAD SHALL go to WRITEBACK.
REQ-012 WRITEBACK SHALL last 1 cycle with reg_write=1 and wb_sel: LOAD 1, JAL/JALR 2, otherwise 0; it then goes to FETCH.
REQ-013 Instruction class SHALL be latched on leaving DECODE; instr changes after that point SHALL NOT alter the sequence.
REQ-014 mem_ready SHALL be ignored outside FETCH and MEMORY.
REQ-015 Outputs not named for a state SHALL be 0.
REQ-016 TRAP SHALL be absorbing: trap=1 and all enables 0 until rst.
REQ-017 Funct3/Funct7 validity is checked downstream; this block SHALL NOT trap on them.

Reset
REQ-018 While rst=1 at a rising edge, next state SHALL be FETCH, trap SHALL be 0 and the latched class SHALL be cleared, including mid-handshake.
REQ-019 During rst, all outputs except the FETCH defaults SHALL read 0; mem_req SHALL be 0 while rst is asserted.

Structure
REQ-020 A shared package SHALL hold:
- the ALUOp encoding constants (R_type..branches);
- the opcode constants;
- the state enum;
- the alu_src_b and wb_sel encodings.
REQ-021 The opcode-to-class decoder SHALL be a sub-module, opcode_decoder (combinational), instantiated once.

Verification
REQ-022 Bench SHALL cover ADD 0x002081B3 with mem_ready low 2 cycles in FETCH:
- FETCH x3 (ir_write=1 on the third), DECODE, EXECUTE (alu_op=0), WRITEBACK (reg_write=1, wb_sel=0), then FETCH; 6 cycles total.
REQ-023 Bench SHALL cover LW 0x0000A183 with mem_ready delayed 3 cycles in MEMORY:
- mem_addr_sel=1 and mem_we=0 held 4 cycles, then WRITEBACK with wb_sel=1.
REQ-024 Bench SHALL cover SW 0x0020A023:
- MEMORY with mem_we=1, then FETCH directly; reg_write never 1.
REQ-025 Bench SHALL cover BEQ 0x00208463:
- EXECUTE with alu_op=4, pc_write_cond=1, pc_src=1, then FETCH; no WRITEBACK.
REQ-026 Bench SHALL cover illegal instr 0x00000000:
- TRAP after DECODE, trap=1 held 20 cycles despite mem_ready toggling; rst clears to FETCH.
REQ-027 Bench SHALL cover rst asserted in MEMORY during a pending store:
- next cycle in FETCH, mem_we=0, trap=0.
